pipeline_control_unit: RTL and testbench

Pipelined control generator for the 5-stage MIPS core. It decodes the ID-stage opcode into the select and enable lines for the RegDst, ALUSrc, MemtoReg and PCSrc multiplexers and for data memory. It carries those lines through the ID/EX, EX/MEM and MEM/WB control registers so each arrives in the stage that uses it. It also detects load-use hazards (stall) and taken branches (flush).

---
 rtl/mips_ctrl_pkg.sv | 41 ++++
 rtl/control_decoder.sv | 23 ++
 rtl/pipeline_control_unit.sv | 107 ++++++++++
 tb/tb_pipeline_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the MIPS pipeline control path.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Narrower bundles carried past EX: only the fields later stages consume.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
    } exmem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decode of the primary opcode into the control bundle.
module control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: ctrl = ctrl_t'({1'b1, 1'b0, ALUOP_FUNCT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            OP_LW:    ctrl = ctrl_t'({1'b0, 1'b1, ALUOP_ADD,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
            OP_SW:    ctrl = ctrl_t'({1'b0, 1'b1, ALUOP_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
            OP_BEQ:   ctrl = ctrl_t'({1'b0, 1'b0, ALUOP_SUB,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
            OP_ADDI:  ctrl = ctrl_t'({1'b0, 1'b1, ALUOP_ADD,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control for the 5-stage MIPS core: decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall detection and taken-branch squash.
module pipeline_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter bit HAZARD_EN = 1'b1,
    parameter bit FLUSH_EN  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_zero,
    output logic       stall,
    output logic       if_flush,
    output logic       ex_reg_dst,
    output logic       ex_alu_src,
    output logic [1:0] ex_alu_op,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       pc_src,
    output logic       wb_reg_write,
    output logic       wb_mem_to_reg,
    output logic       illegal_op
);

    ctrl_t       dec_ctrl;
    logic        dec_illegal;

    ctrl_t       ctrl_p0;
    logic [4:0]  rt_p0;
    logic        illegal_p0;
    exmem_ctrl_t ctrl_p1;
    logic        zero_p1;
    memwb_ctrl_t ctrl_p2;

    logic        flush;
    logic        hazard;

    control_decoder u_decoder (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign pc_src   = ctrl_p1.branch & zero_p1;
    assign flush    = FLUSH_EN & pc_src;
    assign if_flush = flush;

    assign hazard = HAZARD_EN & ctrl_p0.mem_read & (rt_p0 != 5'd0) &
                    ((rt_p0 == id_rs) | (rt_p0 == id_rt));
    // A squashed instruction must not hold the PC, so flush overrides stall.
    assign stall  = hazard & ~flush;

    // ID -> EX
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_p0    <= CTRL_BUBBLE;
            rt_p0      <= 5'd0;
            illegal_p0 <= 1'b0;
        end else begin
            rt_p0 <= id_rt;
            if (stall || flush) begin
                ctrl_p0    <= CTRL_BUBBLE;
                illegal_p0 <= 1'b0;
            end else begin
                ctrl_p0    <= dec_ctrl;
                illegal_p0 <= dec_illegal;
            end
        end
    end

    // EX -> MEM
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ctrl_p1 <= '0;
            zero_p1 <= 1'b0;
        end else begin
            ctrl_p1 <= '{mem_read:   ctrl_p0.mem_read,
                         mem_write:  ctrl_p0.mem_write,
                         branch:     ctrl_p0.branch,
                         reg_write:  ctrl_p0.reg_write,
                         mem_to_reg: ctrl_p0.mem_to_reg};
            zero_p1 <= ex_zero;
        end
    end

    // MEM -> WB
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_p2 <= '0;
        end else begin
            ctrl_p2 <= '{reg_write: ctrl_p1.reg_write, mem_to_reg: ctrl_p1.mem_to_reg};
        end
    end

    assign ex_reg_dst    = ctrl_p0.reg_dst;
    assign ex_alu_src    = ctrl_p0.alu_src;
    assign ex_alu_op     = ctrl_p0.alu_op;
    assign illegal_op    = illegal_p0;
    assign mem_mem_read  = ctrl_p1.mem_read;
    assign mem_mem_write = ctrl_p1.mem_write;
    assign wb_reg_write  = ctrl_p2.reg_write;
    assign wb_mem_to_reg = ctrl_p2.mem_to_reg;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed and randomized bench for pipeline_control_unit against an instruction-slot model.
module tb_pipeline_control_unit;

    localparam logic [5:0] R    = 6'd0;
    localparam logic [5:0] LW   = 6'd35;
    localparam logic [5:0] SW   = 6'd43;
    localparam logic [5:0] BEQ  = 6'd4;
    localparam logic [5:0] ADDI = 6'd8;

    // Decode table rows: {RegDst, ALUSrc, ALUOp[1:0], MemRead, MemWrite, Branch, RegWrite, MemtoReg}
    localparam logic [5:0] T_OP  [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8};
    localparam logic [8:0] T_CTL [5] = '{9'b1_0_10_0_0_0_1_0, 9'b0_1_00_1_0_0_1_1,
                                         9'b0_1_00_0_1_0_0_0, 9'b0_0_01_0_0_1_0_0,
                                         9'b0_1_00_0_0_0_1_0};

    logic       clock;
    logic       reset;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_zero;
    logic       stall, if_flush, ex_reg_dst, ex_alu_src, mem_mem_read, mem_mem_write;
    logic       pc_src, wb_reg_write, wb_mem_to_reg, illegal_op;
    logic [1:0] ex_alu_op;

    pipeline_control_unit dut (
        .clock         (clock),
        .reset         (reset),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_zero       (ex_zero),
        .stall         (stall),
        .if_flush      (if_flush),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .pc_src        (pc_src),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .illegal_op    (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each pipeline slot holds the instruction itself; controls are looked up when observed.
    typedef struct packed {
        logic       vld;
        logic [5:0] op;
        logic [4:0] rt;
        logic       zero;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int    total = 0;
    int    passed = 0;
    int    failed = 0;
    logic  seen_stall, seen_flush, seen_pc;

    wire logic [8:0] regs_obs = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_mem_read,
                                 mem_mem_write, wb_reg_write, wb_mem_to_reg, illegal_op};
    wire logic [5:0] exmem_obs = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_mem_read, mem_mem_write};

    function automatic logic [9:0] lookup(input logic [5:0] op);
        logic [9:0] r;
        r = 10'b1_000000000;
        for (int i = 0; i < 5; i++)
            if (T_OP[i] == op) r = {1'b0, T_CTL[i]};
        return r;
    endfunction

    function automatic logic [8:0] ctl_of(input slot_t s);
        logic [9:0] r;
        r = lookup(s.op);
        return s.vld ? r[8:0] : 9'd0;
    endfunction

    function automatic logic illegal_of(input slot_t s);
        logic [9:0] r;
        r = lookup(s.op);
        return s.vld & r[9];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic z);
        logic [8:0] e, m, w;
        logic       pc, fl, hz, st;
        reset = r; id_opcode = op; id_rs = rs; id_rt = rt; ex_zero = z;
        #1;
        e  = ctl_of(m_ex);
        m  = ctl_of(m_mem);
        pc = m[2] & m_mem.zero;
        fl = pc;
        hz = e[4] && (m_ex.rt != 5'd0) && ((m_ex.rt == rs) || (m_ex.rt == rt));
        st = hz & ~fl;
        check("comb", {29'd0, stall, if_flush, pc_src}, {29'd0, st, fl, pc});
        seen_stall = stall; seen_flush = if_flush; seen_pc = pc_src;
        @(posedge clock);
        if (r) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = fl ? slot_t'(0) : slot_t'({m_ex.vld, m_ex.op, m_ex.rt, z});
            m_ex  = (st || fl) ? slot_t'(0) : slot_t'({1'b1, op, rt, 1'b0});
        end
        #1;
        e = ctl_of(m_ex); m = ctl_of(m_mem); w = ctl_of(m_wb);
        check("regs", {23'd0, regs_obs},
              {23'd0, e[8], e[7], e[6:5], m[4], m[3], w[1], w[0], illegal_of(m_ex)});
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; id_opcode = '0; id_rs = '0; id_rt = '0; ex_zero = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        @(negedge clock);

        step(1, R, 0, 0, 0);
        step(1, R, 0, 0, 0);
        check("reset_regs", {23'd0, regs_obs}, 32'd0);

        // R-type through the pipe
        step(0, R, 1, 2, 0);
        check("rtype_ex_reg_dst", {31'd0, ex_reg_dst}, 32'd1);
        check("rtype_ex_alu_op", {30'd0, ex_alu_op}, 32'd2);
        step(0, SW, 0, 0, 0);
        step(0, SW, 0, 0, 0);
        check("rtype_wb", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'b10);

        // load-use with rt=5
        step(0, LW, 0, 5, 0);
        step(0, R, 5, 6, 0);
        check("lu_stall", {31'd0, seen_stall}, 32'd1);
        check("lu_bubble_ex", {28'd0, ex_reg_dst, ex_alu_src, ex_alu_op}, 32'd0);
        step(0, R, 5, 6, 0);
        check("lu_stall_once", {31'd0, seen_stall}, 32'd0);
        check("lu_add_ex", {28'd0, ex_reg_dst, ex_alu_src, ex_alu_op}, 32'b1010);

        // load to $0 never stalls
        step(0, LW, 0, 0, 0);
        step(0, R, 0, 6, 0);
        check("lu_r0_nostall", {31'd0, seen_stall}, 32'd0);

        // taken branch
        step(0, BEQ, 1, 2, 0);
        step(0, R, 1, 2, 1);
        step(0, R, 3, 4, 0);
        check("beq_taken_pc", {30'd0, seen_pc, seen_flush}, 32'b11);
        check("beq_taken_squash", {26'd0, exmem_obs}, 32'd0);

        // not-taken branch
        step(0, BEQ, 1, 2, 0);
        step(0, R, 1, 2, 0);
        step(0, R, 3, 4, 0);
        check("beq_nt_pc", {30'd0, seen_pc, seen_flush}, 32'b00);

        // taken branch in MEM with a load-use hazard behind it
        step(0, BEQ, 1, 2, 0);
        step(0, LW, 0, 5, 1);
        step(0, R, 5, 6, 0);
        check("flush_wins_stall", {31'd0, seen_stall}, 32'd0);
        check("flush_wins_pc", {31'd0, seen_pc}, 32'd1);
        check("flush_wins_squash", {26'd0, exmem_obs}, 32'd0);

        // back-to-back beq: second squashed when first taken
        step(0, BEQ, 1, 2, 0);
        step(0, BEQ, 1, 2, 1);
        step(0, R, 3, 4, 1);
        check("beq2_first_taken", {31'd0, seen_pc}, 32'd1);
        step(0, R, 3, 4, 0);
        check("beq2_second_squashed", {31'd0, seen_pc}, 32'd0);

        // undefined opcode
        step(0, 6'h3F, 0, 0, 0);
        check("illegal_set", {27'd0, illegal_op, ex_reg_dst, ex_alu_src, ex_alu_op}, 32'b10000);
        step(0, R, 0, 0, 0);
        check("illegal_once", {31'd0, illegal_op}, 32'd0);

        // reset with a load in MEM
        step(0, LW, 0, 7, 0);
        step(0, SW, 0, 0, 0);
        check("lw_in_mem", {31'd0, mem_mem_read}, 32'd1);
        step(1, SW, 0, 0, 0);
        check("midreset_clear", {29'd0, mem_mem_read, wb_reg_write, illegal_op}, 32'd0);
        step(0, SW, 0, 0, 0);
        check("midreset_no_wb", {31'd0, wb_reg_write}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            case ($urandom % 8)
                0: op = R;
                1: op = LW;
                2: op = SW;
                3: op = BEQ;
                4: op = ADDI;
                default: op = 6'($urandom);
            endcase
            step(($urandom % 50) == 0, op, 5'($urandom % 4), 5'($urandom % 4), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
